// File: rtl/bubble_pkg.sv
// Shared definitions for the BUBBLE core: opcode map, sequencer state encoding
// and opcode-class helpers.
package bubble_pkg;

    localparam logic [5:0] OP_LOAD         = 6'd12;
    localparam logic [5:0] OP_STORE        = 6'd13;
    localparam logic [5:0] OP_BR_LO        = 6'd14;
    localparam logic [5:0] OP_BR_HI        = 6'd19;
    localparam logic [5:0] OP_J            = 6'd20;
    localparam logic [5:0] OP_JR           = 6'd21;
    localparam logic [5:0] OP_JAL          = 6'd22;
    localparam logic [5:0] HALT_OP_DEFAULT = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op >= OP_BR_LO) && (op <= OP_BR_HI);
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return (op >= OP_J) && (op <= OP_JAL);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/bubble_pc_unit.sv
// Next-PC selection: unconditional jumps, alu_cond-qualified branches, or
// sequential increment wrapping modulo 2^PC_W.
module bubble_pc_unit
    import bubble_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic [5:0]      opcode,
    input  logic            alu_cond,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc_next
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc + PC_ONE;

    always_comb begin
        pc_next = pc_inc;
        if (is_jump(opcode)) begin
            pc_next = target;
        end else if (is_cond_branch(opcode) && alu_cond) begin
            pc_next = target;
        end
    end

endmodule

// File: rtl/bubble_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the BUBBLE core. Owns
// PC and IR; turns the decoder's level write enables into single-cycle strobes.
module bubble_sequencer
    import bubble_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [5:0]      HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic            dec_branch,
    input  logic            dec_we,
    input  logic            dec_dmem_we,
    input  logic [31:0]     dec_offset,
    input  logic            alu_cond,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic            dmem_we,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    state_t          state_reg;
    state_t          state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [31:0]     ir_reg;
    logic [5:0]      opcode;

    // Branch class and store-ness are taken from the IR opcode itself, so the
    // decoder's duplicate class flags are not needed here.
    logic unused_dec;
    assign unused_dec = ^{dec_branch, dec_dmem_we, dec_offset[31:PC_W]};

    assign opcode = ir_reg[31:26];

    bubble_pc_unit #(
        .PC_W (PC_W)
    ) u_pc_unit (
        .pc       (pc_reg),
        .opcode   (opcode),
        .alu_cond (alu_cond),
        .target   (dec_offset[PC_W-1:0]),
        .pc_next  (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH && imem_ack) begin
                ir_reg <= imem_rdata;
            end
            if (state_reg == ST_EXECUTE) begin
                pc_reg <= pc_next;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = (opcode == HALT_OP) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_mem_op(opcode)) begin
                    state_next = ST_MEM;
                end else if (!is_cond_branch(opcode) && dec_we) begin
                    state_next = ST_WB;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ack) begin
                    state_next = (opcode == OP_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign ir        = ir_reg;

endmodule
